// File: rtl/qspi_xip_pkg.sv
// Shared definitions for the XIP cache flash-fill path.
package qspi_xip_pkg;

  localparam logic [7:0]  CMD_QIO_READ = 8'hEB;
  localparam int unsigned CMD_CLKS     = 8;
  localparam int unsigned ADDR_CLKS    = 6;
  localparam int unsigned MODE_CLKS    = 2;

  // Encoding is also used by the cache controller's debug view.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_MODE  = 3'd3,
    ST_DUMMY = 3'd4,
    ST_DATA  = 3'd5,
    ST_DONE  = 3'd6
  } fetch_state_e;

endpackage

// File: rtl/qspi_line_shreg.sv
// Nibble-in shift register that presents the assembled line in little-endian byte order.
module qspi_line_shreg
  import qspi_xip_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    shift_en_i,
  input  logic [3:0]              nib_i,
  output logic [LINE_BYTES*8-1:0] line_c_o
);

  localparam int unsigned LINE_W = LINE_BYTES * 8;
  // The final nibble is taken straight from nib_i, so one nibble less is stored.
  localparam int unsigned SR_W   = LINE_W - 4;

  logic [SR_W-1:0]   sr_q, sr_d;
  logic [LINE_W-1:0] stream_c;

  // Clear wins over shift; first nibble received ends up at the top.
  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (shift_en_i) begin
      sr_d = {sr_q[SR_W-5:0], nib_i};
    end
  end

  // Shift register storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign stream_c = {sr_q, nib_i};

  // First byte on the wire (top of stream) lands in line[7:0].
  always_comb begin
    line_c_o = '0;
    for (int k = 0; k < int'(LINE_BYTES); k++) begin
      line_c_o[8*k +: 8] = stream_c[LINE_W-8-8*k +: 8];
    end
  end

endmodule

// File: rtl/qspi_line_fetch.sv
// Quad I/O Read (0xEB) line fill engine for the XIP cache.
module qspi_line_fetch
  import qspi_xip_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned DUMMY_CLKS = 4,
  parameter logic [7:0]  MODE_BYTE  = 8'h00
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    req,
  input  logic [23:0]             addr,
  output logic                    busy,
  output logic                    done,
  output logic [LINE_BYTES*8-1:0] line,
  output logic                    sck,
  output logic                    ce_n,
  input  logic [3:0]              din,
  output logic [3:0]              dout,
  output logic                    douten
);

  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned DATA_CLKS  = 2 * LINE_BYTES;
  localparam int unsigned MAX_PH     = (DATA_CLKS > DUMMY_CLKS) ? DATA_CLKS : DUMMY_CLKS;
  localparam int unsigned CNT_W      = $clog2(MAX_PH);
  localparam logic [23:0] ALIGN_MASK = ~24'(LINE_BYTES - 1);

  fetch_state_e      state_q, state_d;
  logic [23:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sck_q, sck_d;
  logic              ce_n_q, ce_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              douten_q, douten_d;
  logic [3:0]        dout_q, dout_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic              ph_last_c;
  fetch_state_e      nib_st_c;
  logic [2:0]        nib_idx_c;
  logic [3:0]        nib_c;
  logic              sh_clr_c, sh_en_c;
  logic [LINE_W-1:0] sh_line_c;

  qspi_line_shreg #(.LINE_BYTES(LINE_BYTES)) u_shreg (
    .clk_i      (HCLK),
    .rst_ni     (HRESETn),
    .clr_i      (sh_clr_c),
    .shift_en_i (sh_en_c),
    .nib_i      (din),
    .line_c_o   (sh_line_c)
  );

  // Last sck cycle of the current phase.
  always_comb begin
    ph_last_c = 1'b0;
    case (state_q)
      ST_CMD:   ph_last_c = (cnt_q == CNT_W'(CMD_CLKS - 1));
      ST_ADDR:  ph_last_c = (cnt_q == CNT_W'(ADDR_CLKS - 1));
      ST_MODE:  ph_last_c = (cnt_q == CNT_W'(MODE_CLKS - 1));
      ST_DUMMY: ph_last_c = (cnt_q == CNT_W'(DUMMY_CLKS - 1));
      ST_DATA:  ph_last_c = (cnt_q == CNT_W'(DATA_CLKS - 1));
      default:  ph_last_c = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: phases advance on the sck fall that ends their last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req)                state_d = ST_CMD;
      ST_CMD:   if (sck_q && ph_last_c) state_d = ST_ADDR;
      ST_ADDR:  if (sck_q && ph_last_c) state_d = ST_MODE;
      ST_MODE:  if (sck_q && ph_last_c) state_d = ST_DUMMY;
      ST_DUMMY: if (sck_q && ph_last_c) state_d = ST_DATA;
      ST_DATA:  if (sck_q && ph_last_c) state_d = ST_DONE;
      ST_DONE:                          state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Nibble to present during the sck cycle that follows the current fall.
  assign nib_st_c  = ph_last_c ? state_d : state_q;
  assign nib_idx_c = ph_last_c ? 3'd0 : 3'(cnt_q + 1'b1);

  always_comb begin
    nib_c = 4'h0;
    case (nib_st_c)
      ST_CMD:  nib_c = {3'b111, CMD_QIO_READ[3'd7 - nib_idx_c]};
      ST_ADDR: nib_c = 4'(addr_q >> (5'd20 - {nib_idx_c, 2'b00}));
      ST_MODE: nib_c = nib_idx_c[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
      default: nib_c = 4'h0;
    endcase
  end

  // Output and datapath next values; pins only move on sck falls or at acceptance.
  always_comb begin
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    sck_d    = sck_q;
    ce_n_d   = ce_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    douten_d = douten_q;
    dout_d   = dout_q;
    line_d   = line_q;
    sh_clr_c = 1'b0;
    sh_en_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d   = addr & ALIGN_MASK;
          cnt_d    = '0;
          sck_d    = 1'b0;
          ce_n_d   = 1'b0;
          busy_d   = 1'b1;
          douten_d = 1'b1;
          dout_d   = {3'b111, CMD_QIO_READ[7]};
          sh_clr_c = 1'b1;
        end
      end
      ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA: begin
        sck_d = ~sck_q;
        if (sck_q) begin
          cnt_d    = ph_last_c ? '0 : CNT_W'(cnt_q + 1'b1);
          dout_d   = nib_c;
          douten_d = (nib_st_c == ST_CMD) || (nib_st_c == ST_ADDR) || (nib_st_c == ST_MODE);
          if (state_q == ST_DATA) begin
            sh_en_c = 1'b1;
            if (ph_last_c) begin
              line_d = sh_line_c;
              ce_n_d = 1'b1;
              busy_d = 1'b0;
              done_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        sck_d    = 1'b0;
        ce_n_d   = 1'b1;
        douten_d = 1'b0;
        busy_d   = 1'b0;
      end
      default: begin
        sck_d    = 1'b0;
        ce_n_d   = 1'b1;
        douten_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      cnt_q    <= '0;
      sck_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      douten_q <= 1'b0;
      dout_q   <= 4'h0;
      line_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      sck_q    <= sck_d;
      ce_n_q   <= ce_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      douten_q <= douten_d;
      dout_q   <= dout_d;
      line_q   <= line_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign line   = line_q;
  assign sck    = sck_q;
  assign ce_n   = ce_n_q;
  assign dout   = dout_q;
  assign douten = douten_q;

endmodule

// File: tb/tb_qspi_line_fetch.sv
// Bench for qspi_line_fetch with a behavioural quad-I/O flash on the SIO bus.
`timescale 1ns/1ps
module tb_qspi_line_fetch;

  localparam int unsigned LB        = 16;
  localparam int unsigned DUMMY     = 4;
  localparam int          DATA_RISE = 8 + 6 + 2 + DUMMY;
  localparam int          LAT_DONE  = 2 * (8 + 6 + 2 + DUMMY + 2 * LB) + 1;  // 105

  localparam logic [127:0] L00 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] L10 = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0] LA0 = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
  localparam logic [127:0] LFF = 128'hFDFCFBFAF9F8F7F6F5F4F3F2F1F0EFEE;
  localparam logic [127:0] L20 = 128'h2F2E2D2C2B2A29282726252423222120;
  localparam logic [127:0] L30 = 128'h3F3E3D3C3B3A39383736353433323130;
  localparam logic [127:0] L40 = 128'h4F4E4D4C4B4A49484746454443424140;

  typedef struct packed {
    logic [23:0]  a;
    logic [127:0] line;
  } vec_t;

  logic         HCLK    = 1'b0;
  logic         HRESETn = 1'b0;
  logic         req     = 1'b0;
  logic [23:0]  addr    = 24'h0;
  logic         busy, done, sck, ce_n, douten;
  logic [127:0] line;
  logic [3:0]   din, dout;

  logic         fl_oe   = 1'b0;
  logic [3:0]   fl_dout = 4'h0;

  assign din = douten ? dout : (fl_oe ? fl_dout : 4'hF);

  qspi_line_fetch #(
    .LINE_BYTES (LB),
    .DUMMY_CLKS (DUMMY),
    .MODE_BYTE  (8'h00)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req     (req),
    .addr    (addr),
    .busy    (busy),
    .done    (done),
    .line    (line),
    .sck     (sck),
    .ce_n    (ce_n),
    .din     (din),
    .dout    (dout),
    .douten  (douten)
  );

  always #5 HCLK = ~HCLK;

  int vecs  = 0;
  int fails = 0;

  task automatic chk_n(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_l(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Flash contents: byte[i] = i below 256, a simple address hash above.
  function automatic logic [7:0] fl_byte(input logic [23:0] a);
    return 8'(a[7:0] + a[15:8] + a[23:16]);
  endfunction

  // Flash model: samples on sck rise, launches data on sck fall after the dummy cycles.
  int          rises  = 0;
  int          nib_n  = 0;
  int          hi_err = 0;
  logic        sck_prev = 1'b0;
  logic [7:0]  cmd_sh = 8'h0, mode_sh = 8'h0, cap_cmd = 8'h0, cap_mode = 8'h0;
  logic [23:0] adr_sh = 24'h0, cap_adr = 24'h0;
  logic [7:0]  fl_b;

  always @(sck, ce_n) begin
    if (ce_n) begin
      rises = 0;
      nib_n = 0;
      fl_oe = 1'b0;
    end else if (sck && !sck_prev) begin
      rises++;
      if (rises == 1) begin
        cap_cmd  = 8'h0;
        cap_adr  = 24'h0;
        cap_mode = 8'hFF;
      end
      if (rises <= 8) begin
        cmd_sh = {cmd_sh[6:0], din[0]};
        if (din[3:1] !== 3'b111) hi_err++;
      end else if (rises <= 14) begin
        adr_sh = {adr_sh[19:0], din};
      end else if (rises <= 16) begin
        mode_sh = {mode_sh[3:0], din};
        if (rises == 16) begin
          cap_cmd  = cmd_sh;
          cap_adr  = adr_sh;
          cap_mode = mode_sh;
        end
      end
    end else if (!sck && sck_prev && rises >= DATA_RISE) begin
      fl_b    = fl_byte(adr_sh + 24'(nib_n / 2));
      fl_dout = (nib_n % 2 == 1) ? fl_b[3:0] : fl_b[7:4];
      fl_oe   = 1'b1;
      nib_n++;
    end
    sck_prev = sck;
  end

  // Scoreboard and bus monitor.
  vec_t q[$];
  int   cyc       = 0;
  int   start_cyc = 0;
  int   done_cnt  = 0;
  int   dten_err  = 0;
  int   cont_err  = 0;
  int   hi_run    = 0;
  int   last_gap  = -1;
  logic busy_prev = 1'b0;
  logic ce_prev   = 1'b1;
  logic exp_dten;
  vec_t e;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (busy && !busy_prev) start_cyc = cyc;
      if (ce_n) begin
        hi_run++;
      end else begin
        if (ce_prev) last_gap = hi_run;
        hi_run = 0;
      end
      exp_dten = !ce_n && (rises < 16 || (rises == 16 && sck));
      if (douten !== exp_dten) dten_err++;
      if (douten && fl_oe) cont_err++;
      if (done) begin
        done_cnt++;
        chk_n("done_has_expect", q.size() > 0 ? 1 : 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk_l("line", line, e.line);
          chk_n("latency", cyc - start_cyc + 1, LAT_DONE);
          chk_n("cmd_byte", int'(cap_cmd), 32'hEB);
          chk_n("addr_sent", int'(cap_adr), int'(e.a & 24'hFFFFF0));
          chk_n("mode_byte", int'(cap_mode), 0);
        end
      end
    end
    busy_prev = busy;
    ce_prev   = ce_n;
  end

  task automatic wait_busy(input string nm);
    for (int n = 0; n < 300 && !busy; n++) @(negedge HCLK);
    chk_n(nm, int'(busy), 1);
  endtask

  task automatic wait_drain(input string nm);
    for (int n = 0; n < 300 && q.size() != 0; n++) @(negedge HCLK);
    chk_n(nm, q.size(), 0);
  endtask

  task automatic run_fetch(input logic [23:0] a, input logic [127:0] l);
    req  = 1'b1;
    addr = a;
    q.push_back({a, l});
    wait_busy("accept");
    req = 1'b0;
    wait_drain("drain");
    repeat (3) @(negedge HCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int   d0;
    tbl[0] = {24'h000000, L00};
    tbl[1] = {24'h000013, L10};
    tbl[2] = {24'h0000AB, LA0};
    tbl[3] = {24'hFFFFF0, LFF};

    repeat (3) @(negedge HCLK);
    chk_l("rst_line", line, 128'h0);
    chk_n("rst_busy", int'(busy), 0);
    chk_n("rst_done", int'(done), 0);
    chk_n("rst_ce_n", int'(ce_n), 1);
    chk_n("rst_sck", int'(sck), 0);
    chk_n("rst_douten", int'(douten), 0);
    chk_n("rst_dout", int'(dout), 0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // Single fetches from the table.
    for (int i = 0; i < 4; i++) run_fetch(tbl[i].a, tbl[i].line);

    // Back-to-back with req held high; addr change while busy is ignored.
    d0   = done_cnt;
    req  = 1'b1;
    addr = 24'h000020;
    q.push_back({24'h000020, L20});
    wait_busy("b2b_first");
    addr = 24'h000030;
    q.push_back({24'h000030, L30});
    for (int n = 0; n < 300 && busy; n++) @(negedge HCLK);
    wait_busy("b2b_second");
    req = 1'b0;
    @(negedge HCLK);
    chk_n("b2b_ce_gap", last_gap, 2);
    wait_drain("b2b_drain");
    chk_n("b2b_dones", done_cnt - d0, 2);
    repeat (3) @(negedge HCLK);

    // Reset in the middle of DATA aborts without a done.
    req  = 1'b1;
    addr = 24'h000000;
    q.push_back({24'h000000, L00});
    wait_busy("rst_accept");
    req = 1'b0;
    repeat (59) @(negedge HCLK);
    chk_l("no_partial_line", line, L30);
    d0 = done_cnt;
    #1 HRESETn = 1'b0;
    #1;
    chk_n("abort_ce_n", int'(ce_n), 1);
    chk_n("abort_sck", int'(sck), 0);
    chk_n("abort_douten", int'(douten), 0);
    chk_n("abort_dout", int'(dout), 0);
    chk_n("abort_busy", int'(busy), 0);
    chk_n("abort_done", int'(done), 0);
    chk_l("abort_line", line, 128'h0);
    q.delete();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (120) @(negedge HCLK);
    chk_n("abort_no_done", done_cnt - d0, 0);
    run_fetch(24'h000040, L40);

    // Stray req pulses during a fetch are dropped.
    d0   = done_cnt;
    req  = 1'b1;
    addr = 24'h000000;
    q.push_back({24'h000000, L00});
    wait_busy("stray_accept");
    req = 1'b0;
    repeat (9) @(negedge HCLK);
    req  = 1'b1;
    addr = 24'h000050;
    @(negedge HCLK);
    req = 1'b0;
    repeat (39) @(negedge HCLK);
    req = 1'b1;
    @(negedge HCLK);
    req = 1'b0;
    wait_drain("stray_drain");
    repeat (5) @(negedge HCLK);
    chk_n("stray_dones", done_cnt - d0, 1);
    chk_n("stray_idle", int'(busy), 0);

    chk_n("douten_profile_errs", dten_err, 0);
    chk_n("sio_contention", cont_err, 0);
    chk_n("cmd_hold_wp_bits", hi_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
